float_monitor: RTL and testbench

Synthesizable, parametrised float activity monitor for simulation and on-chip debug of the float datapath. It watches CHANNELS float buses of configurable exponent and mantissa width and detects bit-level changes on each. Every change becomes a timestamped, classified record, arbitrated round-robin into a FIFO and drained over a valid/ready stream. It supersedes the testbench-only, single-channel, fixed-32-bit float display.

---
 rtl/float_pkg.sv | 27 ++
 rtl/float_monitor_fifo.sv | 46 ++++
 rtl/float_monitor.sv | 168 ++++++++++++++++
 tb/tb_float_monitor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Float helpers shared by the float datapath blocks: class codes, total-width
// arithmetic and field-based classification.
package float_pkg;

  localparam logic [2:0] CLS_ZERO      = 3'd0;
  localparam logic [2:0] CLS_SUBNORMAL = 3'd1;
  localparam logic [2:0] CLS_NORMAL    = 3'd2;
  localparam logic [2:0] CLS_INF       = 3'd3;
  localparam logic [2:0] CLS_NAN       = 3'd4;

  function automatic int unsigned float_width(int unsigned exp_w, int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Index width that stays legal for a single-entry selector.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Classification from pre-reduced field flags so any exponent/mantissa width can use it.
  function automatic logic [2:0] classify(logic exp_zero, logic exp_ones, logic man_zero);
    if (exp_zero) return man_zero ? CLS_ZERO : CLS_SUBNORMAL;
    if (exp_ones) return man_zero ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/float_monitor_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; a push is accepted while full
// when a pop happens in the same cycle.
module float_monitor_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign level_o = wptr_q - rptr_q;
  // Head is forced to zero when empty so idle outputs read as zero.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/float_monitor.sv
// Multi-channel float activity monitor: detects bit-level changes, timestamps and
// classifies them, and streams records out. Optional FLOAT_MONITOR_DISPLAY_EN prints each.
module float_monitor
  import float_pkg::*;
#(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAN_W    = 23,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_W     = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [CHANNELS*float_width(EXP_W, MAN_W)-1:0] in_num,
  input  logic [CHANNELS-1:0]                         in_valid,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [idx_width(CHANNELS)-1:0]              out_chan,
  output logic [2:0]                                  out_class,
  output logic [float_width(EXP_W, MAN_W)-1:0]        out_num,
  output logic [TS_W-1:0]                             out_ts,
  output logic [15:0]                                 drop_cnt,
  output logic [$clog2(DEPTH):0]                      fifo_level
);

  localparam int unsigned FW = float_width(EXP_W, MAN_W);
  localparam int unsigned CW = idx_width(CHANNELS);
  localparam int unsigned RW = CW + 3 + FW + TS_W;

  logic [TS_W-1:0]     ts_q;
  logic [FW-1:0]       last_q     [CHANNELS];
  logic [FW-1:0]       pend_num_q [CHANNELS];
  logic [TS_W-1:0]     pend_ts_q  [CHANNELS];
  logic [CHANNELS-1:0] seen_q, pending_q, change, gnt_oh;
  logic [CW-1:0]       ptr_q, gnt_idx;
  logic                gnt_found, gnt_en;
  logic [15:0]         drop_q, drop_d;

  logic              fifo_empty, fifo_full, fifo_pop;
  logic [RW-1:0]     fifo_wdata, fifo_rdata;
  logic [FW-1:0]     gnt_num;
  logic [EXP_W-1:0]  gnt_exp;
  logic [MAN_W-1:0]  gnt_man;
  logic [2:0]        gnt_cls;

  // Bitwise compare: +0/-0 count as a change, a repeated NaN pattern does not.
  always_comb begin
    change = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      change[c] = in_valid[c] & (~seen_q[c] | (in_num[c*FW +: FW] != last_q[c]));
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    logic [CW-1:0] idx;
    idx       = ptr_q;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!gnt_found && pending_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
      idx = (idx == CW'(CHANNELS - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign fifo_pop = out_valid & out_ready;
  assign gnt_en   = gnt_found & (~fifo_full | fifo_pop);

  always_comb begin
    gnt_oh = '0;
    drop_d = drop_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      gnt_oh[c] = gnt_en && (gnt_idx == CW'(c));
      // A change over a still-pending value loses the older one unless it leaves this cycle.
      if (change[c] && pending_q[c] && !gnt_oh[c] && drop_d != 16'hFFFF) begin
        drop_d = drop_d + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q      <= '0;
      drop_q    <= '0;
      ptr_q     <= '0;
      seen_q    <= '0;
      pending_q <= '0;
    end else begin
      ts_q   <= ts_q + 1'b1;
      drop_q <= drop_d;
      if (gnt_en) ptr_q <= (gnt_idx == CW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (change[c]) begin
          seen_q[c]    <= 1'b1;
          pending_q[c] <= 1'b1;
        end else if (gnt_oh[c]) begin
          pending_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (change[c]) begin
        last_q[c]     <= in_num[c*FW +: FW];
        pend_num_q[c] <= in_num[c*FW +: FW];
        pend_ts_q[c]  <= ts_q;
      end
    end
  end

  assign gnt_num    = pend_num_q[gnt_idx];
  assign gnt_exp    = gnt_num[FW-2 -: EXP_W];
  assign gnt_man    = gnt_num[MAN_W-1:0];
  assign gnt_cls    = classify(gnt_exp == '0, &gnt_exp, gnt_man == '0);
  assign fifo_wdata = {gnt_idx, gnt_cls, gnt_num, pend_ts_q[gnt_idx]};

  float_monitor_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (gnt_en),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign out_valid = ~fifo_empty;
  assign {out_chan, out_class, out_num, out_ts} = fifo_rdata;
  assign drop_cnt  = drop_q;

`ifdef FLOAT_MONITOR_DISPLAY_EN
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  function automatic real to_real(logic [FW-1:0] v);
    real mag;
    int  e;
    e   = int'(v[FW-2 -: EXP_W]);
    mag = real'(v[MAN_W-1:0]) / (2.0 ** MAN_W);
    if (e == 0) mag = mag * (2.0 ** (1 - BIAS));
    else        mag = (1.0 + mag) * (2.0 ** (e - BIAS));
    return v[FW-1] ? -mag : mag;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (out_class == CLS_INF)
        $display("[float_monitor] ch%0d t=%0d: %s", out_chan, out_ts, "inf");
      else if (out_class == CLS_NAN)
        $display("[float_monitor] ch%0d t=%0d: %s", out_chan, out_ts, "nan");
      else
        $display("[float_monitor] ch%0d t=%0d: %f", out_chan, out_ts, to_real(out_num));
    end
  end
`else
  // Display disabled: synthesizable build with no simulation-only code.
`endif

endmodule

// File: tb/tb_float_monitor.sv
// Self-checking bench for float_monitor: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based reference model.
module tb_float_monitor;

  localparam int CH    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [CH*32-1:0] in_num;
  logic [CH-1:0]    in_valid;
  logic             out_ready;
  logic             out_valid;
  logic [1:0]       out_chan;
  logic [2:0]       out_class;
  logic [31:0]      out_num;
  logic [15:0]      out_ts, drop_cnt;
  logic [3:0]       fifo_level;

  logic        h_valid, h_out_valid;
  logic [15:0] h_in, h_num, h_ts, h_drop;
  logic [0:0]  h_chan;
  logic [2:0]  h_class;
  logic [3:0]  h_level;
  logic        h_ready = 1'b1;

  float_monitor dut (
    .clk(clk), .rst(rst), .in_num(in_num), .in_valid(in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_class(out_class), .out_num(out_num), .out_ts(out_ts),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  float_monitor #(.EXP_W(5), .MAN_W(10), .CHANNELS(1)) dut_half (
    .clk(clk), .rst(rst), .in_num(h_in), .in_valid(h_valid),
    .out_valid(h_out_valid), .out_ready(h_ready), .out_chan(h_chan),
    .out_class(h_class), .out_num(h_num), .out_ts(h_ts),
    .drop_cnt(h_drop), .fifo_level(h_level)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          chan;
    int          cls;
    logic [31:0] num;
    int          ts;
  } rec_t;

  rec_t        q[$];
  logic [31:0] m_last [CH];
  logic [31:0] m_pnum [CH];
  bit          m_seen [CH];
  bit          m_pend [CH];
  int          m_pts  [CH];
  int          m_ptr, m_ts, m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_class(logic [31:0] v);
    int e, m;
    e = int'(v[30:23]);
    m = int'(v[22:0]);
    if (e == 0)   return (m == 0) ? 0 : 1;
    if (e == 255) return (m == 0) ? 3 : 4;
    return 2;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < CH; c++) begin
      m_seen[c] = 0;
      m_pend[c] = 0;
    end
    m_ptr = 0; m_ts = 0; m_drop = 0;
  endtask

  // One clock of the monitor as the rules describe it, from pre-edge state and inputs.
  task automatic model_step();
    int   g;
    bit   pop, room;
    rec_t r;
    if (rst) begin
      model_reset();
      return;
    end
    g    = -1;
    pop  = (q.size() > 0) && out_ready;
    room = (q.size() < DEPTH) || pop;
    if (room) begin
      for (int k = 0; k < CH; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
      end
    end
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      r.chan = g; r.cls = ref_class(m_pnum[g]); r.num = m_pnum[g]; r.ts = m_pts[g];
      q.push_back(r);
      m_ptr = (g + 1) % CH;
    end
    for (int c = 0; c < CH; c++) begin
      logic [31:0] v;
      v = in_num[c*32 +: 32];
      if (in_valid[c] && (!m_seen[c] || v != m_last[c])) begin
        if (m_pend[c] && c != g && m_drop < 65535) m_drop++;
        m_pend[c] = 1; m_pnum[c] = v; m_pts[c] = m_ts;
        m_last[c] = v; m_seen[c] = 1;
      end else if (c == g) begin
        m_pend[c] = 0;
      end
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("drop_cnt", drop_cnt, m_drop);
    if (q.size() != 0) begin
      chk("out_chan", out_chan, q[0].chan);
      chk("out_class", out_class, q[0].cls);
      chk("out_num", out_num, q[0].num);
      chk("out_ts", out_ts, q[0].ts);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] fresh(int c);
    logic [31:0] v;
    v = $urandom;
    if (m_seen[c] && v == m_last[c]) v = ~v;
    return v;
  endfunction

  task automatic put(input int c, input logic [31:0] v);
    in_num[c*32 +: 32] = v;
    in_valid = CH'(1) << c;
    cycle();
    in_valid = '0;
  endtask

  task automatic put_class(input logic [31:0] v, input int exp_cls);
    put(0, v);
    cycle();
    chk("class_valid", out_valid, 1);
    chk("class_code", out_class, exp_cls);
    chk("class_num", out_num, v);
    cycle();
  endtask

  task automatic burst();
    for (int c = 0; c < CH; c++) in_num[c*32 +: 32] = fresh(c);
    in_valid = '1;
    cycle();
    in_valid = '0;
  endtask

  logic [31:0] pool [8] = '{32'h0, 32'h80000000, 32'h1, 32'h7F800000,
                            32'hFF800000, 32'h7FC00000, 32'h3F800000, 32'h7F7FFFFF};
  logic [31:0] last_pop, ch1_final, pre;
  logic [15:0] hvals [3] = '{16'h7C00, 16'h0001, 16'h3C00};
  int          hcls  [3] = '{3, 1, 2};
  int          npop;

  initial begin
    rst = 1'b1; in_num = '0; in_valid = '0; out_ready = 1'b0;
    h_in = '0; h_valid = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_num", out_num, 0);
    chk("rst_out_ts", out_ts, 0);
    chk("rst_out_chan", out_chan, 0);

    // First record: latency of two edges, ts equals counter at the sampling edge.
    out_ready = 1'b1;
    in_num[31:0] = 32'h3F800000;
    in_valid = 4'b0001;
    cycle();
    chk("lat_not_yet", out_valid, 0);
    cycle();
    chk("first_valid", out_valid, 1);
    chk("first_chan", out_chan, 0);
    chk("first_class", out_class, 2);
    chk("first_num", out_num, 32'h3F800000);
    chk("first_ts", out_ts, 0);
    repeat (5) cycle();
    in_valid = '0;
    chk("repeat_no_rec", fifo_level, 0);

    put_class(32'h7FC00000, 4);
    put_class(32'h80000000, 0);
    put_class(32'h00000001, 1);
    put_class(32'hFF800000, 3);
    put_class(32'h7F7FFFFF, 2);

    // Grant ch3 so the pointer wraps to 0, then two simultaneous bursts.
    put(3, fresh(3));
    repeat (3) cycle();
    for (int b = 0; b < 2; b++) begin
      burst();
      for (int i = 0; i < CH; i++) begin
        cycle();
        chk("burst_order", out_chan, i);
      end
      cycle();
    end

    // Fill the FIFO with the consumer stalled, then overwrite ch1 three times.
    out_ready = 1'b0;
    burst();
    repeat (5) cycle();
    burst();
    repeat (5) cycle();
    chk("full_level", fifo_level, 8);
    for (int k = 0; k < 3; k++) begin
      in_num[63:32] = fresh(1);
      in_valid = 4'b0010;
      cycle();
    end
    in_valid = '0;
    ch1_final = in_num[63:32];
    cycle();
    chk("drop_two", drop_cnt, 2);
    out_ready = 1'b1;
    npop = 0;
    last_pop = '0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid && out_ready) begin
        npop++;
        last_pop = out_num;
      end
      cycle();
    end
    chk("drain_count", npop, 9);
    chk("drain_last", last_pop, ch1_final);

    // Randomized traffic with repeats, specials and back-pressure.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 3))
          0:       in_num[c*32 +: 32] = pool[$urandom_range(0, 7)];
          1:       in_num[c*32 +: 32] = $urandom;
          default: ;
        endcase
      end
      in_valid  = CH'($urandom);
      out_ready = (i % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      cycle();
    end
    in_valid = '0;

    // Reset with records queued discards them; the old value is then reported again.
    out_ready = 1'b1;
    repeat (12) cycle();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) in_num[c*32 +: 32] = fresh(c);
    in_valid = 4'b0111;
    cycle();
    in_valid = '0;
    repeat (4) cycle();
    chk("pre_rst_level", fifo_level, 3);
    pre = in_num[31:0];
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_num", out_num, 0);
    out_ready = 1'b1;
    in_valid = 4'b0001;
    cycle();
    in_valid = '0;
    cycle();
    chk("rereport_valid", out_valid, 1);
    chk("rereport_num", out_num, pre);
    chk("rereport_chan", out_chan, 0);
    cycle();

    // Half-precision instance.
    for (int i = 0; i < 3; i++) begin
      h_in = hvals[i];
      h_valid = 1'b1;
      cycle();
      h_valid = 1'b0;
      cycle();
      chk("half_valid", h_out_valid, 1);
      chk("half_class", h_class, hcls[i]);
      chk("half_num", h_num, hvals[i]);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
